// File: rtl/sgm_agg135_path.sv
// sgm_agg135_path: 135-degree SGM path aggregation, two-stage pipeline advanced by clken/flush.
module sgm_agg135_path #(
  parameter int ND = 64,
  parameter int CW = 5,
  parameter int P1 = 1,
  parameter int P2 = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             flush,
  input  logic             sof,
  input  logic [10:0]      width,
  input  logic [ND*CW-1:0] cost_in,
  input  logic [ND-1:0]    cost_valid_in,
  input  logic [ND*CW-1:0] prev_in,
  input  logic             prev_valid,
  input  logic [ND-1:0]    prev_mask,
  output logic [ND*CW-1:0] agg_out,
  output logic [ND-1:0]    agg_valid_out,
  output logic [CW-1:0]    min_out,
  output logic             out_en
);
  localparam int DW = ND * CW;
  localparam int IW = CW + 2;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [IW-1:0] XMAX = IW'(CMAX);
  logic          adv;
  logic [10:0]   x_q, y_q, x_d, y_d, cx, cy;
  logic          use_prev, last_col;
  logic [DW-1:0] p_d, c_q, p_q, lr_d, agg_q;
  logic [ND-1:0] cm_q, vld_q;
  logic [CW-1:0] pmin_d, pmin_q, lmin_d, min_q, pk;
  logic          up_q, s1v_q, en_q;
  assign adv = clken | flush;
  always_comb begin
    cx       = sof ? 11'd0 : x_q;
    cy       = sof ? 11'd0 : y_q;
    last_col = cx == width - 11'd1;
    use_prev = prev_valid && cy != 11'd0 && !last_col;
    x_d      = last_col ? 11'd0 : cx + 11'd1;
    y_d      = last_col ? (cy == 11'h7ff ? cy : cy + 11'd1) : cy;
  end
  // Masked previous-row lanes read as the maximum cost so they never win a min.
  always_comb begin
    p_d    = '0;
    pmin_d = CMAX;
    pk     = '0;
    for (int k = 0; k < ND; k++) begin
      pk = prev_mask[k] ? prev_in[k*CW +: CW] : CMAX;
      p_d[k*CW +: CW] = pk;
      pmin_d = pk < pmin_d ? pk : pmin_d;
    end
  end
  for (genvar i = 0; i < ND; i++) begin : g_lane
    logic [IW-1:0] pc, pl, pr, pp, m0, m1, m, s;
    assign pc = IW'(p_q[i*CW +: CW]);
    if (i == 0) begin : g_l0
      assign pl = '1;
    end else begin : g_l
      assign pl = IW'(p_q[(i-1)*CW +: CW]) + IW'(P1);
    end
    if (i == ND - 1) begin : g_rn
      assign pr = '1;
    end else begin : g_r
      assign pr = IW'(p_q[(i+1)*CW +: CW]) + IW'(P1);
    end
    assign pp = IW'(pmin_q) + IW'(P2);
    assign m0 = pc < pl ? pc : pl;
    assign m1 = m0 < pr ? m0 : pr;
    assign m  = m1 < pp ? m1 : pp;
    assign s  = IW'(c_q[i*CW +: CW]) + m - IW'(pmin_q);
    assign lr_d[i*CW +: CW] = !cm_q[i] ? CMAX : !up_q ? c_q[i*CW +: CW] :
                              s > XMAX ? CMAX : s[CW-1:0];
  end
  // Invalid lanes are forced to the maximum, so a plain min equals the min over valid lanes.
  always_comb begin
    lmin_d = CMAX;
    for (int k = 0; k < ND; k++)
      lmin_d = lr_d[k*CW +: CW] < lmin_d ? lr_d[k*CW +: CW] : lmin_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
      cm_q   <= '0;
      p_q    <= '0;
      pmin_q <= '0;
      up_q   <= 1'b0;
      s1v_q  <= 1'b0;
      agg_q  <= '0;
      vld_q  <= '0;
      min_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q <= adv & s1v_q;
      if (adv && s1v_q) begin
        agg_q <= lr_d;
        vld_q <= cm_q;
        min_q <= lmin_d;
      end
      if (clken) begin
        x_q    <= x_d;
        y_q    <= y_d;
        c_q    <= cost_in;
        cm_q   <= cost_valid_in;
        p_q    <= p_d;
        pmin_q <= pmin_d;
        up_q   <= use_prev;
        s1v_q  <= 1'b1;
      end else if (flush) begin
        s1v_q <= 1'b0;
      end
    end
  end
  assign agg_out       = agg_q;
  assign agg_valid_out = vld_q;
  assign min_out       = min_q;
  assign out_en        = en_q;
endmodule

// File: tb/tb_sgm_agg135_path.sv
// tb_sgm_agg135_path: randomized and directed checks against an integer reference model.
module tb_sgm_agg135_path;
  localparam int ND = 64;
  localparam int CW = 5;
  localparam int DW = ND * CW;
  logic          clk = 1'b0, rst = 1'b0, clken = 1'b0, flush = 1'b0, sof = 1'b0;
  logic          prev_valid = 1'b0;
  logic [10:0]   width = 11'd8;
  logic [DW-1:0] cost_in = '0, prev_in = '0, agg_out;
  logic [ND-1:0] cost_valid_in = '0, prev_mask = '0, agg_valid_out;
  logic [CW-1:0] min_out;
  logic          out_en;
  int n_tests = 0, n_fail = 0;
  int c[ND], p[ND];
  int mx = 0, my = 0, pend_min = 0, exp_min = 0;
  bit pend_v = 0, exp_en = 0;
  logic [DW-1:0] pend_agg = '0, exp_agg = '0, t3v;
  logic [ND-1:0] pend_vld = '0, exp_vld = '0, m4;
  sgm_agg135_path dut (
    .clk(clk), .rst(rst), .clken(clken), .flush(flush), .sof(sof), .width(width),
    .cost_in(cost_in), .cost_valid_in(cost_valid_in), .prev_in(prev_in),
    .prev_valid(prev_valid), .prev_mask(prev_mask), .agg_out(agg_out),
    .agg_valid_out(agg_valid_out), .min_out(min_out), .out_en(out_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Lr from the path formula on plain integers; also advances the pixel position.
  task automatic model_px(output logic [DW-1:0] a, output int mn);
    int pv[ND];
    int pmn, v;
    bit use_p;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    use_p = prev_valid && my != 0 && mx != int'(width) - 1;
    if (mx == int'(width) - 1) begin
      mx = 0;
      my = my < 2047 ? my + 1 : 2047;
    end else mx++;
    pmn = 31;
    for (int d = 0; d < ND; d++) begin
      pv[d] = prev_mask[d] ? p[d] : 31;
      if (pv[d] < pmn) pmn = pv[d];
    end
    mn = 31;
    a = '0;
    for (int d = 0; d < ND; d++) begin
      if (!cost_valid_in[d]) v = 31;
      else if (!use_p) v = c[d];
      else begin
        v = pv[d];
        if (d > 0) begin
          if (pv[d-1] + 1 < v) v = pv[d-1] + 1;
        end
        if (d < ND - 1) begin
          if (pv[d+1] + 1 < v) v = pv[d+1] + 1;
        end
        if (pmn + 3 < v) v = pmn + 3;
        v = c[d] + v - pmn;
        if (v > 31) v = 31;
      end
      a[d*CW +: CW] = CW'(v);
      if (cost_valid_in[d] && v < mn) mn = v;
    end
  endtask
  task automatic step(input bit ce, input bit fl, input bit so);
    clken = ce;
    flush = fl;
    sof   = so;
    for (int d = 0; d < ND; d++) begin
      cost_in[d*CW +: CW] = CW'(c[d]);
      prev_in[d*CW +: CW] = CW'(p[d]);
    end
    @(posedge clk);
    if (ce || fl) begin
      exp_en = pend_v;
      if (pend_v) begin
        exp_agg = pend_agg;
        exp_vld = pend_vld;
        exp_min = pend_min;
      end
      if (ce) begin
        model_px(pend_agg, pend_min);
        pend_vld = cost_valid_in;
        pend_v = 1;
      end else pend_v = 0;
    end else exp_en = 0;
    #1;
    chk("out_en", DW'(out_en), DW'(exp_en));
    chk("agg_out", agg_out, exp_agg);
    chk("agg_valid_out", DW'(agg_valid_out), DW'(exp_vld));
    chk("min_out", DW'(min_out), DW'(exp_min));
    clken = 1'b0;
    flush = 1'b0;
    sof   = 1'b0;
  endtask
  task automatic fill(input int cv, input int pv);
    for (int d = 0; d < ND; d++) begin
      c[d] = cv;
      p[d] = pv;
    end
    cost_valid_in = '1;
    prev_mask = '1;
  endtask
  task automatic fill_rand();
    for (int d = 0; d < ND; d++) begin
      c[d] = $urandom_range(0, 31);
      p[d] = $urandom_range(0, 31);
    end
    cost_valid_in = ($urandom % 4 == 0) ? {$urandom, $urandom} : '1;
    prev_mask = ($urandom % 4 == 0) ? {$urandom, $urandom} : '1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #2;
    mx = 0;
    my = 0;
    pend_v = 0;
    exp_en = 0;
    exp_agg = '0;
    exp_vld = '0;
    exp_min = 0;
    chk("rst_out_en", DW'(out_en), '0);
    chk("rst_agg", agg_out, '0);
    chk("rst_vld", DW'(agg_valid_out), '0);
    chk("rst_min", DW'(min_out), '0);
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    fill(0, 0);
    repeat (2) @(posedge clk);
    do_reset();
    fill(7, 0);
    step(1, 0, 1);
    fill_rand();
    step(1, 0, 0);
    chk("t1_agg", agg_out, {ND{5'd7}});
    chk("t1_min", DW'(min_out), DW'(7));
    repeat (6) begin
      fill_rand();
      step(1, 0, 0);
    end
    prev_valid = 1'b1;
    fill(2, 4);
    step(1, 0, 0);
    fill(0, 10);
    p[10] = 0;
    step(1, 0, 0);
    chk("t2_agg", agg_out, {ND{5'd2}});
    fill_rand();
    for (int d = 0; d < ND; d++) c[d] = 31;
    cost_valid_in = {$urandom, $urandom};
    m4 = cost_valid_in;
    step(1, 0, 0);
    for (int d = 0; d < ND; d++) t3v[d*CW +: CW] = (d == 10) ? 5'd0 : (d == 9 || d == 11) ? 5'd1 : 5'd3;
    chk("t3_agg", agg_out, t3v);
    chk("t3_min", DW'(min_out), '0);
    fill_rand();
    step(1, 0, 0);
    chk("t4_vld", DW'(agg_valid_out), DW'(m4));
    width = 11'd4;
    fill_rand();
    step(1, 0, 1);
    repeat (8) begin
      fill_rand();
      step(1, 0, 0);
    end
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    width = 11'd6;
    fill_rand();
    step(1, 0, 1);
    repeat (400) begin
      bit ce, fl, so;
      ce = $urandom % 4 != 0;
      fl = !ce && ($urandom % 2 == 0);
      so = ce && ($urandom % 60 == 0);
      prev_valid = $urandom % 5 != 0;
      fill_rand();
      step(ce, fl, so);
    end
    fill_rand();
    step(1, 0, 0);
    do_reset();
    fill_rand();
    step(1, 0, 1);
    fill_rand();
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
